uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares the single UART transmitter among N_REQ byte requesters.
- It sits between the requesters and the UART register port, which has UARTCON at 0xC, UARTTX at 0xD, UARTRX at 0xE and UARTPIN at 0xF.
- Per byte, it loads UARTTX, raises tx_en with the configured baud bits, polls UARTCON.TXC (bit 3) until set, then drops tx_en and acknowledges the requester.
- Firmware can still read UARTCON and UARTRX. This block is the only writer of UARTTX and UARTCON while it is busy.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- POLL_MAX, 16'd60000, maximum POLL cycles before a timeout abort.

Ports:
- clk  in  1  system clock; all state on posedge.
- rst_n  in  1  reset, asynchronous and active-low.
- req  in  N_REQ  level request per requester.
- req_data  in  8*N_REQ  byte for requester i at [8i+7:8i].
- gnt  out  N_REQ  one-cycle pulse; req_data of the granted requester is captured this cycle.
- done  out  N_REQ  one-cycle pulse when the granted byte has finished (or aborted).
- baud_sel  in  2  UARTCON[5:4] value used for every transfer; sampled at grant.
- uart_waddr  out  4  UART write address (addr3).
- uart_wdata  out  8  UART write data (data_in).
- uart_wen  out  1  UART write enable.
- uart_raddr  out  4  UART read address (addr1).
- uart_rdata  in  8  UART read data (data_out1); combinational from uart_raddr.
- busy  out  1  high whenever state != IDLE.
- timeout  out  1  one-cycle pulse, coincident with done, when POLL_MAX is exceeded.

Behaviour:
- Reset values: all outputs 0, state IDLE, rr_ptr = N_REQ-1, poll_cnt = 0, byte/baud/owner registers 0.
- Arbitration: the first i with req[i]=1 in the order rr_ptr+1, rr_ptr+2, ... modulo N_REQ wins. rr_ptr is updated to the winner at grant.
- States and transitions:
  - IDLE: if |req, go to GRANT.
  - GRANT: pulse gnt[win]; latch byte = req_data[win], baud = baud_sel, owner = win. Next state LOAD.
  - LOAD: uart_wen=1, uart_waddr=0xD, uart_wdata=byte. Next state START.
  - START: uart_wen=1, uart_waddr=0xC, uart_wdata={1'b1,1'b0,baud,4'b0000}. poll_cnt cleared. Next state SETTLE.
  - SETTLE: one idle cycle so the UART latches tx_en. Next state POLL.
  - POLL: uart_raddr=0xC. If uart_rdata[3]=1, go to STOP. Else if poll_cnt==POLL_MAX-1, set the abort flag and go to STOP. Else poll_cnt++.
  - STOP: uart_wen=1, uart_waddr=0xC, uart_wdata={2'b00,baud,4'b0000}, which clears tx_en, txc and rxc. Next state DONE.
  - DONE: pulse done[owner]; pulse timeout if aborted; clear the abort flag. Next state IDLE.
- Outside LOAD, START and STOP: uart_wen=0, uart_waddr=0, uart_wdata=0.
- Outside POLL: uart_raddr=0.
- Minimum latency is 7 cycles from gnt to done when TXC is already set on the first POLL cycle (GRANT through DONE, with 1 POLL cycle).
- Requester rules:
  - A requester must deassert req in the cycle after its done if it has no further byte.
  - A req still high in IDLE is a new request. Round-robin order places it behind the other pending requesters.
  - req_data only needs to be valid in the gnt cycle.
- Boundaries:
  - A request arriving while busy waits; nothing is dropped.
  - Simultaneous requests are served in rotation, with no requester getting two grants while another is pending.
  - Requests dropped before grant are never granted.
  - Dropping req after grant has no effect; done still fires.
- Reset mid-transfer: asynchronous return to IDLE; no STOP write is issued, and the UART's own rst_n handles its registers.
- poll_cnt is 16 bits and never wraps, because it is capped at POLL_MAX-1.

Test Plan:
- Single request: req=4'b0001, byte 0x5A, baud_sel=2'b11. Expect gnt[0] the cycle after req. Expect writes (0xD,0x5A), then (0xC,0xB0). TXC model sets bit 3 after 20 cycles. Expect write (0xC,0x30), then done[0]; busy low the next cycle.
- Contention: req=4'b1111 held with rr_ptr at reset. Expect grant order 0,1,2,3,0; each done precedes the next gnt.
- Fairness after wrap: complete a grant to requester 3, then req=4'b1001. Expect requester 0 granted before 3.
- Timeout: POLL_MAX=8 and TXC never set. Expect exactly 8 POLL cycles, the STOP write (0xC,{2'b00,baud,4'b0}), and done[owner] with timeout=1 in the same cycle.
- Reset mid-POLL: assert rst_n=0 asynchronously. Expect busy, gnt, done, uart_wen, uart_waddr, uart_wdata and uart_raddr all 0 immediately. After release with req=4'b0100, expect a normal transfer for requester 2.
- Minimum latency: TXC already set. Expect done exactly 6 cycles after gnt.

Source files
------------

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// Round-robin scheduler that lets N_REQ byte requesters share one UART
// transmitter. For each granted byte it writes UARTTX, enables the
// transmitter through UARTCON, polls UARTCON.TXC until the byte is out
// (or POLL_MAX polls have elapsed), clears UARTCON and signals done.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req / req_data       per-requester level request and byte ([8i+7:8i])
//   gnt                  one-cycle grant pulse; req_data captured this cycle
//   done                 one-cycle completion pulse to the owner
//   baud_sel             UARTCON[5:4] value, sampled at grant
//   uart_waddr/wdata/wen UART register write port
//   uart_raddr/rdata     UART register read port (rdata combinational)
//   busy                 high whenever a transfer is in progress
//   timeout              pulses with done when the poll limit was hit
module uart_tx_sched #(
  parameter int          N_REQ    = 4,
  parameter logic [15:0] POLL_MAX = 16'd60000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  input  logic [1:0]         baud_sel,
  output logic [3:0]         uart_waddr,
  output logic [7:0]         uart_wdata,
  output logic               uart_wen,
  output logic [3:0]         uart_raddr,
  input  logic [7:0]         uart_rdata,
  output logic               busy,
  output logic               timeout
);

  localparam int             IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [3:0]     ADDR_CON = 4'hC;
  localparam logic [3:0]     ADDR_TX  = 4'hD;
  localparam logic [IW-1:0]  PTR_INIT = IW'(N_REQ - 1);

  typedef enum logic [2:0] {
    IDLE, GRANT, LOAD, START, SETTLE, POLL, STOP, DONE
  } state_t;

  state_t        state_reg, state_next;
  logic [IW-1:0] rr_ptr_reg;
  logic [IW-1:0] owner_reg;
  logic [7:0]    data_reg;
  logic [1:0]    baud_reg;
  logic [15:0]   poll_cnt_reg;
  logic          abort_reg;

  logic [IW-1:0] win;
  logic          any_req;
  logic          txc;
  logic          poll_at_max;
  logic          unused_rdata;

  // Unpack the flat request bus into one byte per requester.
  logic [7:0] req_bytes [N_REQ];
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_bytes[gi] = req_data[8*gi +: 8];
    end
  endgenerate

  assign txc          = uart_rdata[3];
  // Only TXC is consumed; the remaining UARTCON bits are ignored here.
  assign unused_rdata = ^{uart_rdata[7:4], uart_rdata[2:0]};
  assign poll_at_max  = (poll_cnt_reg == POLL_MAX - 16'd1);

  // Search starts just after the last winner, so every pending requester
  // is reached before the previous winner can be picked again.
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!any_req && req[(int'(rr_ptr_reg) + k) % N_REQ]) begin
        any_req = 1'b1;
        win     = IW'((int'(rr_ptr_reg) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    gnt        = '0;
    done       = '0;
    timeout    = 1'b0;
    uart_wen   = 1'b0;
    uart_waddr = 4'h0;
    uart_wdata = 8'h00;
    uart_raddr = 4'h0;
    case (state_reg)
      IDLE: begin
        if (|req) state_next = GRANT;
      end
      GRANT: begin
        // A request withdrawn before this cycle is not granted.
        if (any_req) begin
          gnt        = N_REQ'(1) << win;
          state_next = LOAD;
        end else begin
          state_next = IDLE;
        end
      end
      LOAD: begin
        uart_wen   = 1'b1;
        uart_waddr = ADDR_TX;
        uart_wdata = data_reg;
        state_next = START;
      end
      START: begin
        uart_wen   = 1'b1;
        uart_waddr = ADDR_CON;
        uart_wdata = {1'b1, 1'b0, baud_reg, 4'b0000};
        state_next = SETTLE;
      end
      SETTLE: begin
        state_next = POLL;
      end
      POLL: begin
        uart_raddr = ADDR_CON;
        if (txc || poll_at_max) state_next = STOP;
      end
      STOP: begin
        // Writing zeros in bits 7..6 and 3..0 clears tx_en, txc and rxc.
        uart_wen   = 1'b1;
        uart_waddr = ADDR_CON;
        uart_wdata = {2'b00, baud_reg, 4'b0000};
        state_next = DONE;
      end
      DONE: begin
        done       = N_REQ'(1) << owner_reg;
        timeout    = abort_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= PTR_INIT;
      owner_reg    <= '0;
      data_reg     <= 8'h00;
      baud_reg     <= 2'b00;
      poll_cnt_reg <= 16'd0;
      abort_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        GRANT: begin
          if (any_req) begin
            rr_ptr_reg <= win;
            owner_reg  <= win;
            data_reg   <= req_bytes[win];
            baud_reg   <= baud_sel;
          end
        end
        START: poll_cnt_reg <= 16'd0;
        POLL: begin
          // Counter stops at POLL_MAX-1, so it can never wrap.
          if (!txc) begin
            if (poll_at_max) abort_reg    <= 1'b1;
            else             poll_cnt_reg <= poll_cnt_reg + 16'd1;
          end
        end
        DONE: abort_reg <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched: directed vectors with a scoreboard queue of
// expected grant / UART write / done events, plus a small UART model that
// raises TXC a programmable number of cycles after tx_en is written.
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // Main instance (default POLL_MAX)
  logic [3:0]  req1 = '0;
  logic [31:0] req_data1 = '0;
  logic [1:0]  baud1 = '0;
  logic [3:0]  gnt1, done1, waddr1, raddr1;
  logic [7:0]  wdata1, rdata1;
  logic        wen1, busy1, timeout1;

  // Short-timeout instance (POLL_MAX = 8)
  logic [3:0]  req2 = '0;
  logic [31:0] req_data2 = '0;
  logic [1:0]  baud2 = '0;
  logic [3:0]  gnt2, done2, waddr2, raddr2;
  logic [7:0]  wdata2, rdata2;
  logic        wen2, busy2, timeout2;

  uart_tx_sched #(.N_REQ(4), .POLL_MAX(16'd60000)) dut (
    .clk(clk), .rst_n(rst_n), .req(req1), .req_data(req_data1),
    .gnt(gnt1), .done(done1), .baud_sel(baud1),
    .uart_waddr(waddr1), .uart_wdata(wdata1), .uart_wen(wen1),
    .uart_raddr(raddr1), .uart_rdata(rdata1),
    .busy(busy1), .timeout(timeout1)
  );

  uart_tx_sched #(.N_REQ(4), .POLL_MAX(16'd8)) dut_to (
    .clk(clk), .rst_n(rst_n), .req(req2), .req_data(req_data2),
    .gnt(gnt2), .done(done2), .baud_sel(baud2),
    .uart_waddr(waddr2), .uart_wdata(wdata2), .uart_wen(wen2),
    .uart_raddr(raddr2), .uart_rdata(rdata2),
    .busy(busy2), .timeout(timeout2)
  );

  initial forever #5 clk = ~clk;

  // Monitor / UART model look at whichever instance is selected.
  logic sel = 1'b0;
  logic [3:0] m_gnt, m_done, m_waddr, m_raddr;
  logic [7:0] m_wdata;
  logic       m_wen, m_timeout;
  assign m_gnt     = sel ? gnt2     : gnt1;
  assign m_done    = sel ? done2    : done1;
  assign m_waddr   = sel ? waddr2   : waddr1;
  assign m_wdata   = sel ? wdata2   : wdata1;
  assign m_wen     = sel ? wen2     : wen1;
  assign m_raddr   = sel ? raddr2   : raddr1;
  assign m_timeout = sel ? timeout2 : timeout1;

  // UART model
  logic [7:0] con = 8'h00;
  logic       force_txc = 1'b0;
  int         txc_delay = 20;
  int         txc_cnt = 0;
  assign rdata1 = (raddr1 == 4'hC) ? (con | {4'b0, force_txc, 3'b0}) : 8'h00;
  assign rdata2 = (raddr2 == 4'hC) ? (con | {4'b0, force_txc, 3'b0}) : 8'h00;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      con = 8'h00;
      txc_cnt = 0;
    end else if (m_wen && m_waddr == 4'hC) begin
      con = m_wdata;
      txc_cnt = 0;
    end else if (con[7] && !con[3]) begin
      txc_cnt++;
      if (txc_cnt >= txc_delay) con[3] = 1'b1;
    end
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: kind 0 = grant (a = onehot), 1 = write (a = addr, b = data),
  // 2 = done (a = onehot, b = timeout)
  typedef struct {int kind; int a; int b;} ev_t;
  ev_t exp_q[$];

  task automatic push_xfer(input int who, input logic [7:0] data,
                           input logic [1:0] baud, input int to);
    exp_q.push_back('{0, 1 << who, 0});
    exp_q.push_back('{1, 'hD, int'(data)});
    exp_q.push_back('{1, 'hC, int'({2'b10, baud, 4'b0000})});
    exp_q.push_back('{1, 'hC, int'({2'b00, baud, 4'b0000})});
    exp_q.push_back('{2, 1 << who, to});
  endtask

  int gnt_cyc = 0, done_cyc = 0, poll_run = 0, poll_seen = 0;

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      int  k, a, b;
      bit  have;
      ev_t e;
      have = 1'b0; k = 0; a = 0; b = 0;
      if (m_gnt != 0) begin
        have = 1'b1; k = 0; a = int'(m_gnt); gnt_cyc = cyc;
      end else if (m_wen) begin
        have = 1'b1; k = 1; a = int'(m_waddr); b = int'(m_wdata);
        if (m_waddr == 4'hC && m_wdata[7]) poll_run = 0;
      end else if (m_done != 0 || m_timeout) begin
        have = 1'b1; k = 2; a = int'(m_done); b = int'(m_timeout);
        done_cyc = cyc; poll_seen = poll_run;
        $display("xfer done: done=%b timeout=%0d cycle=%0d polls=%0d",
                 m_done, m_timeout, cyc, poll_run);
      end
      if (m_raddr == 4'hC) poll_run++;
      if (have) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got kind=%0d a=%0h b=%0h, expected none",
                   k, a, b);
        end else begin
          e = exp_q.pop_front();
          if (k != e.kind || a != e.a || b != e.b) begin
            errors++;
            $display("FAIL event: got kind=%0d a=%0h b=%0h, expected kind=%0d a=%0h b=%0h",
                     k, a, b, e.kind, e.a, e.b);
          end
        end
      end
    end
  end

  task automatic wait_dones(input int n);
    int seen = 0;
    int budget = 3000;
    while (seen < n && budget > 0) begin
      @(negedge clk);
      if (m_done != 0) seen++;
      budget--;
    end
    if (seen < n) chk("done_wait_timeout", seen, n);
    @(posedge clk); #1;
  endtask

  initial begin
    int req_cyc;
    int budget;
    #3;
    chk("reset_outputs",
        int'({busy1, gnt1, done1, wen1, waddr1, wdata1, raddr1, timeout1}), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Contention from reset pointer: 0,1,2,3,0
    txc_delay = 3;
    req_data1 = 32'h44_33_22_11;
    baud1 = 2'b01;
    push_xfer(0, 8'h11, 2'b01, 0);
    push_xfer(1, 8'h22, 2'b01, 0);
    push_xfer(2, 8'h33, 2'b01, 0);
    push_xfer(3, 8'h44, 2'b01, 0);
    push_xfer(0, 8'h11, 2'b01, 0);
    req1 = 4'b1111;
    wait_dones(5);
    req1 = 4'b0000;
    repeat (2) @(posedge clk); #1;

    // Fairness after wrap: grant 3, then 1001 serves 0 before 3
    push_xfer(3, 8'h44, 2'b01, 0);
    req1 = 4'b1000;
    wait_dones(1);
    req1 = 4'b0000;
    push_xfer(0, 8'h11, 2'b01, 0);
    push_xfer(3, 8'h44, 2'b01, 0);
    req1 = 4'b1001;
    wait_dones(1);
    req1 = 4'b1000;
    wait_dones(1);
    req1 = 4'b0000;
    repeat (2) @(posedge clk); #1;

    // Single request, TXC after 20 cycles
    txc_delay = 20;
    req_data1 = 32'h44_33_22_5A;
    baud1 = 2'b11;
    push_xfer(0, 8'h5A, 2'b11, 0);
    req1 = 4'b0001;
    req_cyc = cyc;
    wait_dones(1);
    req1 = 4'b0000;
    chk("busy_after_done", int'(busy1), 0);
    chk("gnt_latency", gnt_cyc - req_cyc, 1);
    repeat (2) @(posedge clk); #1;

    // Minimum latency: TXC already set
    force_txc = 1'b1;
    req_data1 = 32'h44_33_C3_5A;
    baud1 = 2'b00;
    push_xfer(1, 8'hC3, 2'b00, 0);
    req1 = 4'b0010;
    wait_dones(1);
    req1 = 4'b0000;
    force_txc = 1'b0;
    chk("min_latency", done_cyc - gnt_cyc, 6);
    chk("min_polls", poll_seen, 1);
    repeat (2) @(posedge clk); #1;

    // Timeout on the POLL_MAX=8 instance
    sel = 1'b1;
    txc_delay = 100000;
    req_data2 = 32'h00_7E_00_00;
    baud2 = 2'b10;
    push_xfer(2, 8'h7E, 2'b10, 1);
    req2 = 4'b0100;
    wait_dones(1);
    req2 = 4'b0000;
    chk("timeout_polls", poll_seen, 8);
    chk("timeout_latency", done_cyc - gnt_cyc, 13);
    repeat (2) @(posedge clk); #1;
    sel = 1'b0;

    // Reset in the middle of POLL
    txc_delay = 20;
    req_data1 = 32'h44_33_22_99;
    baud1 = 2'b11;
    exp_q.push_back('{0, 1, 0});
    exp_q.push_back('{1, 'hD, 'h99});
    exp_q.push_back('{1, 'hC, 'hB0});
    req1 = 4'b0001;
    budget = 50;
    do begin
      @(negedge clk);
      budget--;
    end while (raddr1 != 4'hC && budget > 0);
    chk("reach_poll", int'(raddr1), 'hC);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        int'({busy1, gnt1, done1, wen1, waddr1, wdata1, raddr1, timeout1}), 0);
    chk("queue_at_reset", exp_q.size(), 0);
    exp_q.delete();
    req1 = 4'b0000;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    req_data1 = 32'h44_3C_22_99;
    baud1 = 2'b01;
    push_xfer(2, 8'h3C, 2'b01, 0);
    req1 = 4'b0100;
    wait_dones(1);
    req1 = 4'b0000;
    repeat (3) @(posedge clk); #1;

    chk("queue_empty_end", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
